// File: rtl/retire_map_table_pkg.sv
// Shared types for the retirement map table: index types, stage packets and
// the restore FSM state encoding.
package retire_map_table_pkg;

   localparam int AMT_ARCH_REGS = 32;
   localparam int AMT_PHYS_REGS = 64;
   localparam int AMT_RESTORE_W = 4;
   localparam int AMT_AW        = $clog2(AMT_ARCH_REGS);
   localparam int AMT_TW        = $clog2(AMT_PHYS_REGS);
   localparam int AMT_CHUNKS    = AMT_ARCH_REGS / AMT_RESTORE_W;
   localparam int AMT_CW        = $clog2(AMT_CHUNKS);
   localparam int AMT_RW_LG     = $clog2(AMT_RESTORE_W);

   typedef logic [AMT_AW-1:0] ARCH_REG_IDX;
   typedef logic [AMT_TW-1:0] PHYS_REG_IDX;

   typedef struct packed {
      logic        retire_en;
      ARCH_REG_IDX arch;
      PHYS_REG_IDX tag;
      PHYS_REG_IDX told;
   } IR_AMT_PACKET;

   typedef struct packed {
      logic                              valid;
      ARCH_REG_IDX                       base;
      logic [AMT_RESTORE_W-1:0][AMT_TW-1:0] tags;
   } AMT_MT_RESTORE_PACKET;

   typedef struct packed {
      logic        free_en;
      PHYS_REG_IDX free_tag;
   } AMT_FL_PACKET;

   typedef enum logic [1:0] {
      AMT_IDLE   = 2'd0,
      AMT_STREAM = 2'd1,
      AMT_DONE   = 2'd2
   } amt_state_e;

   // First arch index covered by a restore chunk (chunks are RESTORE_W aligned).
   function automatic ARCH_REG_IDX chunk_base(input logic [AMT_CW-1:0] chunk);
      return {chunk, {AMT_RW_LG{1'b0}}};
   endfunction

endpackage

// File: rtl/amt_restore_fsm.sv
// Rollback restore sequencer: walks the committed map in RESTORE_W-entry chunks
// under a valid/ready handshake and pulses done after the final acceptance.
module amt_restore_fsm
   import retire_map_table_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        rollback_req,
   input  logic        restore_ready,
   output logic        restore_valid,
   output ARCH_REG_IDX restore_base,
   output logic        restore_done,
   output logic        busy
);

   localparam logic [AMT_CW-1:0] LAST_CHUNK = AMT_CW'(AMT_CHUNKS - 1);

   amt_state_e          state_r;
   logic [AMT_CW-1:0]   chunk_r;
   logic                valid_r;
   logic                done_r;
   logic                busy_r;

   // State, chunk counter and registered handshake outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= AMT_IDLE;
         chunk_r <= {AMT_CW{1'b0}};
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            AMT_IDLE: begin
               done_r <= 1'b0;
               if (rollback_req) begin
                  state_r <= AMT_STREAM;
                  chunk_r <= {AMT_CW{1'b0}};
                  valid_r <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  valid_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            AMT_STREAM: begin
               // Beat held until accepted; rollback_req is ignored here.
               if (restore_ready) begin
                  if (chunk_r == LAST_CHUNK) begin
                     state_r <= AMT_DONE;
                     valid_r <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     chunk_r <= chunk_r + {{(AMT_CW-1){1'b0}}, 1'b1};
                  end
               end
            end
            AMT_DONE: begin
               state_r <= AMT_IDLE;
               valid_r <= 1'b0;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= AMT_IDLE;
               chunk_r <= {AMT_CW{1'b0}};
               valid_r <= 1'b0;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign restore_valid = valid_r;
   assign restore_base  = chunk_base(chunk_r);
   assign restore_done  = done_r;
   assign busy          = busy_r;

endmodule

// File: rtl/retire_map_table.sv
// Architectural map table at retire: applies commits, frees Told one cycle
// later, and streams the committed mapping back on rollback.
module retire_map_table
   import retire_map_table_pkg::*;
#(
   parameter int ARCH_REGS = AMT_ARCH_REGS,
   parameter int PHYS_REGS = AMT_PHYS_REGS,
   parameter int RESTORE_W = AMT_RESTORE_W
)(
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   retire_en,
   input  logic [$clog2(ARCH_REGS)-1:0]           retire_arch,
   input  logic [$clog2(PHYS_REGS)-1:0]           retire_tag,
   input  logic [$clog2(PHYS_REGS)-1:0]           retire_told,
   output logic                                   free_en,
   output logic [$clog2(PHYS_REGS)-1:0]           free_tag,
   input  logic                                   rollback_req,
   output logic                                   restore_valid,
   input  logic                                   restore_ready,
   output logic [$clog2(ARCH_REGS)-1:0]           restore_base,
   output logic [RESTORE_W*$clog2(PHYS_REGS)-1:0] restore_tags,
   output logic                                   restore_done,
   output logic                                   busy,
   output logic                                   protocol_err
);

   IR_AMT_PACKET         ir_pkt_s;
   AMT_FL_PACKET         fl_pkt_r;
   AMT_MT_RESTORE_PACKET restore_pkt_s;
   PHYS_REG_IDX          map_r [AMT_ARCH_REGS];
   logic                 protocol_err_r;
   logic                 busy_s;
   logic                 restore_valid_s;
   logic                 restore_done_s;
   ARCH_REG_IDX          restore_base_s;
   logic                 commit_s;
   logic                 write_s;

   assign ir_pkt_s = '{retire_en: retire_en, arch: retire_arch,
                       tag: retire_tag, told: retire_told};

   // Commits are dropped while restoring; arch 0 is hardwired to phys 0.
   always_comb begin
      commit_s = ir_pkt_s.retire_en && !busy_s;
      write_s  = commit_s && (ir_pkt_s.arch != {AMT_AW{1'b0}});
   end

   // Committed map storage, identity after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < AMT_ARCH_REGS; i++) begin
            map_r[i] <= PHYS_REG_IDX'(i);
         end
      end else if (write_s) begin
         map_r[ir_pkt_s.arch] <= ir_pkt_s.tag;
      end
   end

   // Told release to the free list, one cycle after the commit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fl_pkt_r <= '{free_en: 1'b0, free_tag: {AMT_TW{1'b0}}};
      end else begin
         fl_pkt_r.free_en <= write_s;
         if (write_s) begin
            fl_pkt_r.free_tag <= ir_pkt_s.told;
         end
      end
   end

   // Sticky flag for commits arriving during a restore.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         protocol_err_r <= 1'b0;
      end else if (ir_pkt_s.retire_en && busy_s) begin
         protocol_err_r <= 1'b1;
      end
   end

   amt_restore_fsm u_restore_fsm (
      .clock         (clock),
      .reset         (reset),
      .rollback_req  (rollback_req),
      .restore_ready (restore_ready),
      .restore_valid (restore_valid_s),
      .restore_base  (restore_base_s),
      .restore_done  (restore_done_s),
      .busy          (busy_s)
   );

   // Beat payload read straight from the map, which cannot change while busy.
   always_comb begin
      restore_pkt_s.valid = restore_valid_s;
      restore_pkt_s.base  = restore_base_s;
      for (int k = 0; k < AMT_RESTORE_W; k++) begin
         restore_pkt_s.tags[k] = map_r[restore_base_s + ARCH_REG_IDX'(k)];
      end
   end

   assign free_en       = fl_pkt_r.free_en;
   assign free_tag      = fl_pkt_r.free_tag;
   assign restore_valid = restore_pkt_s.valid;
   assign restore_base  = restore_pkt_s.base;
   assign restore_tags  = restore_pkt_s.tags;
   assign restore_done  = restore_done_s;
   assign busy          = busy_s;
   assign protocol_err  = protocol_err_r;

endmodule

// File: tb/tb_retire_map_table.sv
// Directed bench for retire_map_table: commits, free pulses, full restores with
// and without backpressure, and reset during a restore.
module tb_retire_map_table;

   localparam int AW = 5;
   localparam int TW = 6;
   localparam int RW = 4;
   localparam int NB = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             retire_en = 1'b0;
   logic [AW-1:0]    retire_arch = 5'd0;
   logic [TW-1:0]    retire_tag = 6'd0;
   logic [TW-1:0]    retire_told = 6'd0;
   logic             free_en;
   logic [TW-1:0]    free_tag;
   logic             rollback_req = 1'b0;
   logic             restore_valid;
   logic             restore_ready = 1'b1;
   logic [AW-1:0]    restore_base;
   logic [RW*TW-1:0] restore_tags;
   logic             restore_done;
   logic             busy;
   logic             protocol_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [TW-1:0] exp_map [32];

   retire_map_table dut (
      .clock(clock), .reset(reset),
      .retire_en(retire_en), .retire_arch(retire_arch),
      .retire_tag(retire_tag), .retire_told(retire_told),
      .free_en(free_en), .free_tag(free_tag),
      .rollback_req(rollback_req), .restore_valid(restore_valid),
      .restore_ready(restore_ready), .restore_base(restore_base),
      .restore_tags(restore_tags), .restore_done(restore_done),
      .busy(busy), .protocol_err(protocol_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic reset_model();
      for (int i = 0; i < 32; i++) exp_map[i] = TW'(i);
   endtask

   task automatic commit(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [TW-1:0] o);
      retire_en = 1'b1; retire_arch = a; retire_tag = t; retire_told = o;
      if (a != 5'd0) exp_map[a] = t;
      tick();
      retire_en = 1'b0;
      chk("free_en", 32'(free_en), (a != 5'd0) ? 32'd1 : 32'd0);
      if (a != 5'd0) chk("free_tag", 32'(free_tag), 32'(o));
      tick();
      chk("free_en_drop", 32'(free_en), 32'd0);
   endtask

   task automatic run_restore(input bit toggle, input bit inject, input bit cmt,
                              input logic [AW-1:0] ca, input logic [TW-1:0] ct,
                              input logic [TW-1:0] co);
      int beats;
      int cyc;
      bit rdy;
      logic [RW*TW-1:0] et;
      beats = 0;
      cyc = 0;
      rollback_req = 1'b1;
      retire_en = cmt; retire_arch = ca; retire_tag = ct; retire_told = co;
      if (cmt && ca != 5'd0) exp_map[ca] = ct;
      tick();
      rollback_req = 1'b0;
      retire_en = 1'b0;
      chk("busy_start", 32'(busy), 32'd1);
      if (cmt) begin
         chk("free_in_stream", 32'(free_en), 32'd1);
         chk("free_tag_stream", 32'(free_tag), 32'(co));
      end
      while (beats < NB && cyc < 100) begin
         for (int k = 0; k < RW; k++) et[k*TW +: TW] = exp_map[beats*RW + k];
         chk("valid", 32'(restore_valid), 32'd1);
         chk("base", 32'(restore_base), 32'(beats*RW));
         chk("tags", 32'(restore_tags), 32'(et));
         chk("done_early", 32'(restore_done), 32'd0);
         rdy = toggle ? (cyc % 3 == 0) : 1'b1;
         restore_ready = rdy;
         if (inject && cyc == 0) begin
            retire_en = 1'b1; retire_arch = 5'd7; retire_tag = 6'd60; retire_told = 6'd7;
         end
         tick();
         retire_en = 1'b0;
         if (inject && cyc == 0) chk("no_free_busy", 32'(free_en), 32'd0);
         if (rdy) beats++;
         cyc++;
      end
      restore_ready = 1'b1;
      chk("beat_cycles", 32'(cyc), toggle ? 32'd22 : 32'd8);
      chk("done", 32'(restore_done), 32'd1);
      chk("valid_done", 32'(restore_valid), 32'd0);
      chk("busy_done", 32'(busy), 32'd1);
      tick();
      chk("done_pulse", 32'(restore_done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      reset_model();
      tick();
      tick();
      chk("rst_free_en", 32'(free_en), 32'd0);
      chk("rst_free_tag", 32'(free_tag), 32'd0);
      chk("rst_valid", 32'(restore_valid), 32'd0);
      chk("rst_base", 32'(restore_base), 32'd0);
      chk("rst_done", 32'(restore_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_perr", 32'(protocol_err), 32'd0);
      reset = 1'b0;
      tick();

      // Identity restore, then commits to arch 3 and arch 0.
      run_restore(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
      commit(5'd3, 6'd40, 6'd3);
      commit(5'd0, 6'd50, 6'd0);
      run_restore(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);

      // Commit coincident with rollback_req, visible in the stream.
      run_restore(1'b0, 1'b0, 1'b1, 5'd5, 6'd41, 6'd5);
      chk("perr_clean", 32'(protocol_err), 32'd0);

      // Backpressured restore with an illegal commit on the first beat.
      run_restore(1'b1, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);
      chk("perr_set", 32'(protocol_err), 32'd1);

      // Reset while beat 3 is on the bus.
      rollback_req = 1'b1;
      tick();
      rollback_req = 1'b0;
      restore_ready = 1'b1;
      repeat (3) tick();
      chk("beat3_base", 32'(restore_base), 32'd12);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(restore_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(restore_done), 32'd0);
      chk("mid_rst_perr", 32'(protocol_err), 32'd0);
      tick();
      reset = 1'b0;
      reset_model();
      repeat (3) begin
         tick();
         chk("no_done_after_rst", 32'(restore_done), 32'd0);
      end
      run_restore(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/retire_map_table.md
Name: retire_map_table

Overview:
- Architectural (retirement) map table at the retire end of the R10K pipeline.
- Consumes the per-cycle commit that stage_ir produces: arch reg, new phys tag, old phys tag (Told).
- Returns Told to the free list and holds the committed arch→phys mapping.
- On a rollback request, streams the committed mapping back to the speculative map table in chunks under a valid/ready handshake.

Parameters:
- ARCH_REGS, 32, number of architectural registers (power of 2).
- PHYS_REGS, 64, number of physical registers.
- RESTORE_W, 4, map entries per restore beat; must divide ARCH_REGS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- retire_en  in  1  commit valid this cycle.
- retire_arch  in  $clog2(ARCH_REGS)  destination arch reg.
- retire_tag  in  $clog2(PHYS_REGS)  new committed phys tag.
- retire_told  in  $clog2(PHYS_REGS)  previous phys tag, to be freed.
- free_en  out  1  Told release valid (to free list).
- free_tag  out  $clog2(PHYS_REGS)  phys tag released.
- rollback_req  in  1  start restore of speculative map (mispredict / exception at retire).
- restore_valid  out  1  restore beat valid.
- restore_ready  in  1  map table accepts beat.
- restore_base  out  $clog2(ARCH_REGS)  first arch index of beat.
- restore_tags  out  RESTORE_W*$clog2(PHYS_REGS)  tags for restore_base..restore_base+RESTORE_W-1; entry k in bits [k*TW +: TW].
- restore_done  out  1  one-cycle pulse after last beat accepted.
- busy  out  1  restore in progress.
- protocol_err  out  1  sticky: retire_en asserted while busy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset state:
  - map[i]=i for all i (identity; matches free list initial state of phys ARCH_REGS..PHYS_REGS-1 free).
  - free_en=0, free_tag=0, restore_valid=0, restore_base=0, restore_done=0, busy=0, protocol_err=0, FSM=IDLE.
- Commit, when retire_en && !busy:
  - map[retire_arch] <= retire_tag at the posedge.
  - Next cycle free_en=1, free_tag=retire_told (1-cycle registered latency).
- retire_arch==0: map unchanged (map[0] fixed at phys 0) and free_en stays 0.
- Commit while busy: ignored (no map write, no free), protocol_err set until reset.
- FSM IDLE → STREAM when rollback_req=1:
  - A commit in the same cycle is applied first and is visible in the stream.
  - Chunk counter = 0, busy=1 from the next cycle.
- STREAM:
  - restore_valid=1.
  - restore_base=chunk*RESTORE_W.
  - restore_tags = map[base..base+RESTORE_W-1], read from the live map, which is frozen while busy.
  - Outputs hold stable until restore_valid && restore_ready.
  - On acceptance: chunk+1. On acceptance of the last chunk (ARCH_REGS/RESTORE_W-1), go to DONE.
- DONE: restore_done=1 for exactly one cycle, restore_valid=0, busy=1; then IDLE, busy=0.
- rollback_req during STREAM/DONE: ignored; no restart.
- Minimum latency with ready held high, defaults: req in cycle 0, beats in cycles 1–8, done in cycle 9, idle in cycle 10.
- Reset asserted mid-stream: aborts immediately to reset state; no restore_done.
- free_en and restore are independent. A commit accepted in the rollback_req cycle still produces free_en during the first STREAM cycle.

Decomposition:
- Shared package (sys_defs): ARCH_REG_IDX and PHYS_REG_IDX types; new IR_AMT_PACKET {retire_en, arch, tag, told}; AMT_MT_RESTORE_PACKET {valid, base, tags[RESTORE_W]}; AMT_FL_PACKET {free_en, free_tag}.
- The module converts its flat ports to and from these packets in the stage wrappers.
- One natural sub-module: amt_restore_fsm (IDLE/STREAM/DONE, chunk counter, handshake). The storage array and free register stay in the top module.

Test Plan:
- Reset, then a full restore with ready=1 → 8 beats with base 0,4,…,28, tags equal to identity (beat 1 = {4,5,6,7}), restore_done in cycle 9.
- Commit arch 3, tag 40, told 3 → free_en=1, free_tag=3 next cycle; a subsequent restore shows map[3]=40 in the beat with base 0.
- Commit arch 0, tag 50, told 0 → free_en stays 0; restore shows map[0]=0.
- Commit arch 5, tag 41 in the same cycle as rollback_req → beat with base 4 carries tag 41 at slot 1; free_en pulses in the first STREAM cycle.
- restore_ready toggling 1,0,0,1… → beat outputs stable across stalls; exactly 8 acceptances; single done pulse. retire_en during STREAM → protocol_err=1, map unchanged.
- Reset asserted at beat 3 → restore_valid and busy drop asynchronously, no restore_done, map back to identity.
